ee354_final_project: RTL and testbench

- Multi-cycle integer determinant engine for an 8x8 matrix of signed 8-bit entries.
- Uses fraction-free (Bareiss) Gaussian elimination with row-swap pivoting.
- Controlled by a Start/Ack handshake through five one-hot states: I, Enter, Load, Comp, Done.
- Sits behind a host or bench that supplies a flattened matrix and reads a 32-bit signed result.

---
 rtl/ee354_final_project.sv | 178 +++++++++++++++++
 tb/tb_ee354_final_project.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_final_project.sv
// 8x8 signed integer determinant engine using fraction-free (Bareiss)
// elimination with row-swap pivoting, one element update per cycle.
//
// state | meaning
// I     | idle; det holds the last result; waits for Start
// Enter | sign-extend the input bus into a[][], clear k/prev/sign
// Load  | find a nonzero pivot for column k (swap rows if needed)
// Comp  | update one a[i][j] per cycle for i,j in k+1..7
// Done  | det valid and held; waits for Ack
module ee354_final_project (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Ack,
  input  logic [511:0] input_arr_flat,
  output logic [31:0]  det,
  output logic         q_I,
  output logic         q_Enter,
  output logic         q_Load,
  output logic         q_Comp,
  output logic         q_Done
);

  localparam int N  = 8;
  localparam int EW = 8;
  localparam int IW = 72;
  localparam int PW = 2 * IW;

  typedef enum logic [4:0] {
    S_I     = 5'b00001,
    S_ENTER = 5'b00010,
    S_LOAD  = 5'b00100,
    S_COMP  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [2:0]           i_q, i_d;
  logic [2:0]           j_q, j_d;
  logic signed [IW-1:0] prev_q, prev_d;
  logic                 sign_neg_q, sign_neg_d;
  logic [31:0]          det_q, det_d;
  logic signed [IW-1:0] a_q [N][N];
  logic signed [IW-1:0] a_d [N][N];

  logic signed [PW-1:0] akk_w, aij_w, aik_w, akj_w, prev_w;
  logic signed [IW-1:0] upd;
  logic                 piv_found;
  logic [2:0]           piv_row;

  // Bareiss update for the element currently addressed by (i, j) in step k;
  // the division by the previous pivot is exact, so truncation loses nothing.
  always_comb begin
    akk_w  = PW'(a_q[k_q][k_q]);
    aij_w  = PW'(a_q[i_q][j_q]);
    aik_w  = PW'(a_q[i_q][k_q]);
    akj_w  = PW'(a_q[k_q][j_q]);
    prev_w = PW'(prev_q);
    upd    = IW'((akk_w * aij_w - aik_w * akj_w) / prev_w);
  end

  // Lowest-indexed row below k with a nonzero entry in column k.
  always_comb begin
    piv_found = 1'b0;
    piv_row   = k_q;
    for (int r = N - 1; r >= 0; r--) begin
      if (r > int'(k_q) && a_q[r][k_q] != '0) begin
        piv_found = 1'b1;
        piv_row   = 3'(r);
      end
    end
  end

  // Next-state, loop counters and array updates.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    i_d        = i_q;
    j_d        = j_q;
    prev_d     = prev_q;
    sign_neg_d = sign_neg_q;
    det_d      = det_q;
    a_d        = a_q;
    unique case (state_q)
      S_I: begin
        if (Start) state_d = S_ENTER;
      end
      S_ENTER: begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            a_d[r][c] = IW'(signed'(input_arr_flat[(63 - (8*r + c))*8 +: EW]));
          end
        end
        k_d        = 3'd0;
        prev_d     = IW'(1);
        sign_neg_d = 1'b0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        i_d = k_q + 3'd1;
        j_d = k_q + 3'd1;
        if (a_q[k_q][k_q] != '0) begin
          state_d = S_COMP;
        end else if (piv_found) begin
          for (int c = 0; c < N; c++) begin
            a_d[k_q][c]     = a_q[piv_row][c];
            a_d[piv_row][c] = a_q[k_q][c];
          end
          sign_neg_d = ~sign_neg_q;
          state_d    = S_COMP;
        end else begin
          det_d   = 32'd0;
          state_d = S_DONE;
        end
      end
      S_COMP: begin
        a_d[i_q][j_q] = upd;
        if (j_q == 3'd7) begin
          if (i_q == 3'd7) begin
            prev_d = a_q[k_q][k_q];
            k_d    = k_q + 3'd1;
            if (k_q == 3'd6) begin
              // The last element of step 6 is a[7][7] itself.
              det_d   = sign_neg_q ? 32'(-upd) : 32'(upd);
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            i_d = i_q + 3'd1;
            j_d = k_q + 3'd1;
          end
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      S_DONE: begin
        if (Ack) state_d = S_I;
      end
      default: state_d = S_I;
    endcase
  end

  // Control and result registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_I;
      k_q        <= 3'd0;
      i_q        <= 3'd0;
      j_q        <= 3'd0;
      prev_q     <= IW'(1);
      sign_neg_q <= 1'b0;
      det_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      i_q        <= i_d;
      j_q        <= j_d;
      prev_q     <= prev_d;
      sign_neg_q <= sign_neg_d;
      det_q      <= det_d;
    end
  end

  // Matrix storage; contents are reloaded in Enter, so no reset is needed.
  always_ff @(posedge Clk) begin
    a_q <= a_d;
  end

  assign det     = det_q;
  assign q_I     = state_q[0];
  assign q_Enter = state_q[1];
  assign q_Load  = state_q[2];
  assign q_Comp  = state_q[3];
  assign q_Done  = state_q[4];

endmodule

// File: tb/tb_ee354_final_project.sv
// Bench for the determinant engine; reference is the Leibniz permutation
// expansion evaluated modulo 2^64.
module tb_ee354_final_project;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Ack;
  logic [511:0] input_arr_flat;
  logic [31:0]  det;
  logic         q_I, q_Enter, q_Load, q_Comp, q_Done;

  int nvec  = 0;
  int nfail = 0;
  int m [8][8];

  localparam logic [4:0] F_I    = 5'b10000;
  localparam logic [4:0] F_DONE = 5'b00001;

  ee354_final_project dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .input_arr_flat(input_arr_flat), .det(det),
    .q_I(q_I), .q_Enter(q_Enter), .q_Load(q_Load), .q_Comp(q_Comp), .q_Done(q_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] flags();
    return {q_I, q_Enter, q_Load, q_Comp, q_Done};
  endfunction

  function automatic logic [511:0] pack_mat();
    logic [511:0] v;
    v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[(63 - (8*r + c))*8 +: 8] = 8'(m[r][c]);
    return v;
  endfunction

  // Leibniz expansion over all 8! permutations (Heap's algorithm).
  function automatic longint ref_det();
    int p [8];
    int cnt [8];
    longint sum, prod;
    bit neg;
    int i, t;
    for (int q = 0; q < 8; q++) begin p[q] = q; cnt[q] = 0; end
    neg  = 1'b0;
    prod = 1;
    for (int r = 0; r < 8; r++) prod = prod * longint'(m[r][p[r]]);
    sum = prod;
    i = 0;
    while (i < 8) begin
      if (cnt[i] < i) begin
        if (i % 2 == 0) begin t = p[0]; p[0] = p[i]; p[i] = t; end
        else begin t = p[cnt[i]]; p[cnt[i]] = p[i]; p[i] = t; end
        neg  = ~neg;
        prod = 1;
        for (int r = 0; r < 8; r++) prod = prod * longint'(m[r][p[r]]);
        sum = neg ? sum - prod : sum + prod;
        cnt[i] = cnt[i] + 1;
        i = 0;
      end else begin
        cnt[i] = 0;
        i = i + 1;
      end
    end
    return sum;
  endfunction

  function automatic void set_diag(int d);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = (r == c) ? d : 0;
  endfunction

  // Pulse Start, then count edges until q_Done. Optionally keep Start high
  // and pulse Ack while the engine is busy.
  task automatic run_matrix(input bit hold_start, output logic [31:0] got,
                            output int lat, output bit onehot_ok);
    input_arr_flat = pack_mat();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1;
    if (!hold_start) Start = 1'b0;
    lat = 0;
    onehot_ok = 1'b1;
    while (q_Done !== 1'b1 && lat < 400) begin
      if ($countones(flags()) != 1) onehot_ok = 1'b0;
      @(posedge Clk); #1;
      lat++;
      if (hold_start && lat == 20) Ack = 1'b1;
      if (hold_start && lat == 21) Ack = 1'b0;
      if (hold_start && lat == 120) Start = 1'b0;
    end
    Start = 1'b0;
    got = det;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(posedge Clk); #1 Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; input_arr_flat = '0;
    #3 Reset = 1'b0;
    #4;
    nvec++;
    if (flags() !== F_I) begin nfail++; $display("FAIL reset_flags: got %b expected %b", flags(), F_I); end
    nvec++;
    if (det !== 32'd0) begin nfail++; $display("FAIL reset_det: got %0h expected 0", det); end
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    nvec++;
    if (flags() !== F_I) begin nfail++; $display("FAIL idle_hold: got %b expected %b", flags(), F_I); end
  endtask

  task automatic test_identity();
    logic [31:0] got; int lat; bit oh;
    set_diag(1);
    run_matrix(1'b0, got, lat, oh);
    nvec++;
    if (got !== 32'd1) begin nfail++; $display("FAIL identity_det: got %0d expected 1", $signed(got)); end
    nvec++;
    if (lat !== 148) begin nfail++; $display("FAIL identity_latency: got %0d expected 148", lat); end
    nvec++;
    if (oh !== 1'b1) begin nfail++; $display("FAIL identity_onehot: got %0b expected 1", oh); end
    repeat (3) @(posedge Clk);
    #1;
    nvec++;
    if (flags() !== F_DONE || det !== 32'd1) begin
      nfail++; $display("FAIL done_hold: got flags %b det %0d expected %b det 1", flags(), det, F_DONE);
    end
    // Start together with Ack in Done: only Ack matters, so we land in I.
    Start = 1'b1;
    do_ack();
    Start = 1'b0;
    nvec++;
    if (flags() !== F_I || det !== 32'd1) begin
      nfail++; $display("FAIL ack_to_idle: got flags %b det %0d expected %b det 1", flags(), det, F_I);
    end
    @(posedge Clk); #1;
    nvec++;
    if (flags() !== F_I || det !== 32'd1) begin
      nfail++; $display("FAIL idle_keeps_det: got flags %b det %0d expected %b det 1", flags(), det, F_I);
    end
  endtask

  task automatic test_directed();
    logic [31:0] got; int lat; bit oh;
    int expv;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin
          set_diag(1);
          m[5][5] = 7; m[5][6] = 8; m[5][7] = 2;
          m[6][5] = 5; m[6][6] = 2; m[6][7] = 4;
          m[7][5] = 1; m[7][6] = 1; m[7][7] = 9;
          expv = -224;
        end
        1: begin
          set_diag(1);
          m[0][0] = 0; m[0][1] = 1; m[1][0] = 1; m[1][1] = 0;
          expv = -1;
        end
        2: begin set_diag(2);  expv = 256; end
        default: begin set_diag(-1); expv = 1; end
      endcase
      run_matrix(1'b0, got, lat, oh);
      nvec++;
      if (got !== 32'(expv)) begin nfail++; $display("FAIL directed%0d_det: got %0d expected %0d", t, $signed(got), expv); end
      nvec++;
      if (lat !== 148 || oh !== 1'b1) begin
        nfail++; $display("FAIL directed%0d_latency: got %0d onehot %0b expected 148 onehot 1", t, lat, oh);
      end
      do_ack();
    end
  endtask

  task automatic test_singular();
    logic [31:0] got; int lat; bit oh;
    set_diag(1);
    m[0][1] = 1; m[1][0] = 1;
    // Step 0 (1 Load + 49 Comp) zeroes column 1 below row 0, so Load of
    // step 1 exits: 1 Enter + 1 Load + 49 Comp + 1 Load = 52 edges.
    run_matrix(1'b0, got, lat, oh);
    nvec++;
    if (got !== 32'd0) begin nfail++; $display("FAIL singular_det: got %0d expected 0", $signed(got)); end
    nvec++;
    if (lat !== 52) begin nfail++; $display("FAIL singular_latency: got %0d expected 52", lat); end
    do_ack();
  endtask

  task automatic test_reset_mid_comp();
    logic [31:0] got; int lat; bit oh;
    longint r;
    set_diag(3);
    input_arr_flat = pack_mat();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (60) @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    nvec++;
    if (flags() !== F_I || det !== 32'd0) begin
      nfail++; $display("FAIL reset_in_comp: got flags %b det %0d expected %b det 0", flags(), det, F_I);
    end
    @(posedge Clk); #1 Reset = 1'b1;
    for (int q = 0; q < 8; q++)
      for (int c = 0; c < 8; c++)
        m[q][c] = int'($urandom_range(0, 255)) - 128;
    r = ref_det();
    run_matrix(1'b0, got, lat, oh);
    nvec++;
    if (got !== r[31:0]) begin nfail++; $display("FAIL after_reset_det: got %0h expected %0h", got, r[31:0]); end
    do_ack();
  endtask

  task automatic test_random();
    logic [31:0] got; int lat; bit oh;
    longint r;
    for (int t = 0; t < 8; t++) begin
      for (int q = 0; q < 8; q++)
        for (int c = 0; c < 8; c++) begin
          if (t % 2 == 0) m[q][c] = int'($urandom_range(0, 255)) - 128;
          else if ($urandom_range(0, 9) < 6) m[q][c] = 0;
          else m[q][c] = int'($urandom_range(0, 6)) - 3;
        end
      r = ref_det();
      run_matrix(1'b0, got, lat, oh);
      nvec++;
      if (got !== r[31:0]) begin nfail++; $display("FAIL random%0d_det: got %0h expected %0h", t, got, r[31:0]); end
      nvec++;
      if ((r != 0 && lat != 148) || lat > 148 || oh !== 1'b1) begin
        nfail++; $display("FAIL random%0d_latency: got %0d onehot %0b expected %s", t, lat, oh, (r != 0) ? "148" : "<=148");
      end
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got; int lat; bit oh;
    longint r;
    set_diag(127);
    r = ref_det();
    run_matrix(1'b1, got, lat, oh);
    nvec++;
    if (got !== r[31:0]) begin nfail++; $display("FAIL diag127_det: got %0h expected %0h", got, r[31:0]); end
    nvec++;
    if (lat !== 148) begin nfail++; $display("FAIL diag127_latency: got %0d expected 148", lat); end
    do_ack();
    nvec++;
    if (flags() !== F_I) begin nfail++; $display("FAIL diag127_ack: got %b expected %b", flags(), F_I); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_directed();
    test_singular();
    test_reset_mid_comp();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
